// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte producers share one UART transmitter.
// Issues a one-cycle start per granted byte, then follows tx_busy until the frame is done.
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int GAP_CYCLES    = 0,
   parameter int START_TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [7:0]                 tx_data,
   output logic                       tx_start,
   input  logic                       tx_busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       active,
   output logic                       err_timeout,
   output logic [15:0]                sent_count
);

   localparam int ID_W     = $clog2(NUM_REQ);
   localparam int CNT_MAX  = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   localparam logic [CNT_W-1:0] TO_END  = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_LAST);
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      GAP
   } state_t;

   // Where a finished (or abandoned) frame goes: straight back to IDLE when no gap is configured.
   localparam state_t AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

   state_t            state_reg, state_next;
   logic [ID_W-1:0]   last_grant_reg, last_grant_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [7:0]        tx_data_reg, tx_data_next;
   logic              tx_start_reg, tx_start_next;
   logic [ID_W-1:0]   grant_id_reg, grant_id_next;
   logic [15:0]       sent_count_reg, sent_count_next;

   logic [7:0]        req_bytes [NUM_REQ];
   logic              found;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   scan_idx;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_bytes[gi] = req_data[8*gi +: 8];
      end
   endgenerate

   // Search starts one past the last winner, so the most recent winner is checked last.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         scan_idx = ID_W'((int'(last_grant_reg) + i) % NUM_REQ);
         if (!found && req_valid[scan_idx]) begin
            found  = 1'b1;
            winner = scan_idx;
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      cnt_next        = cnt_reg;
      tx_data_next    = tx_data_reg;
      tx_start_next   = 1'b0;
      grant_id_next   = grant_id_reg;
      sent_count_next = sent_count_reg;
      req_ready       = '0;
      err_timeout     = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (found && !rst) begin
               req_ready[winner] = 1'b1;
               tx_data_next      = req_bytes[winner];
               grant_id_next     = winner;
               last_grant_next   = winner;
               tx_start_next     = 1'b1;
               state_next        = ISSUE;
            end
         end
         ISSUE: begin
            cnt_next   = '0;
            state_next = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_next = WAIT_DONE;
            end else if (cnt_reg == TO_END) begin
               err_timeout = 1'b1;
               cnt_next    = '0;
               state_next  = AFTER_FRAME;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               sent_count_next = sent_count_reg + 16'd1;
               cnt_next        = '0;
               state_next      = AFTER_FRAME;
            end
         end
         GAP: begin
            // tx_busy is deliberately not looked at here.
            if (cnt_reg == GAP_END) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= LAST_ID;
         cnt_reg        <= '0;
         tx_data_reg    <= 8'h00;
         tx_start_reg   <= 1'b0;
         grant_id_reg   <= '0;
         sent_count_reg <= 16'd0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         cnt_reg        <= cnt_next;
         tx_data_reg    <= tx_data_next;
         tx_start_reg   <= tx_start_next;
         grant_id_reg   <= grant_id_next;
         sent_count_reg <= sent_count_next;
      end
   end

   assign tx_data    = tx_data_reg;
   assign tx_start   = tx_start_reg;
   assign grant_id   = grant_id_reg;
   assign sent_count = sent_count_reg;
   assign active     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter; tx_busy is played by hand to mimic UART_TX.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int GP = 3;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        active;
   logic        err_timeout;
   logic [15:0] sent_count;

   int checks     = 0;
   int failures   = 0;
   int last_model = N - 1;
   int sent_model = 0;
   int frame_no   = 0;

   uart_tx_arbiter #(
      .NUM_REQ      (N),
      .GAP_CYCLES   (GP),
      .START_TIMEOUT(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .grant_id   (grant_id),
      .active     (active),
      .err_timeout(err_timeout),
      .sent_count (sent_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference round-robin rule: first valid requester after the previous winner, wrapping.
   function automatic int rr_pick(input logic [3:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic do_frame(input logic [3:0] v, input logic [31:0] d, input bit connected);
      int w;
      int dly;
      int len;
      logic [7:0] b;
      w = rr_pick(v, last_model);
      b = d[8*w +: 8];

      req_valid = v;
      req_data  = d;
      #1;
      check("idle_active", 32'(active), 32'd0);
      check("req_ready", 32'(req_ready), 32'd1 << w);

      tick();
      req_valid = 4'h0;
      req_data  = $urandom;
      #1;
      check("tx_start", 32'(tx_start), 32'd1);
      check("tx_data", 32'(tx_data), 32'(b));
      check("grant_id", 32'(grant_id), 32'(w));
      check("ready_low_issue", 32'(req_ready), 32'd0);
      check("issue_active", 32'(active), 32'd1);
      last_model = w;

      if (connected) begin
         dly = $urandom_range(0, 3);
         len = $urandom_range(1, 4);
         for (int i = 0; i <= dly; i++) begin
            tick();
            check("start_one_cycle", 32'(tx_start), 32'd0);
            check("no_early_err", 32'(err_timeout), 32'd0);
         end
         tx_busy = 1'b1;
         for (int i = 0; i < len; i++) begin
            tick();
            check("busy_no_start", 32'(tx_start), 32'd0);
            check("busy_active", 32'(active), 32'd1);
         end
         tx_busy = 1'b0;
         tick();
         sent_model = (sent_model + 1) & 32'hFFFF;
         check("sent_count", 32'(sent_count), 32'(sent_model));
      end else begin
         for (int k = 1; k <= TO; k++) begin
            tick();
            check("err_timeout", 32'(err_timeout), (k == TO) ? 32'd1 : 32'd0);
         end
         tick();
         check("err_one_cycle", 32'(err_timeout), 32'd0);
         check("sent_after_to", 32'(sent_count), 32'(sent_model));
      end

      for (int g = 0; g < GP; g++) begin
         req_valid = 4'hF;
         tx_busy   = 1'($urandom_range(0, 1));
         #1;
         check("gap_no_ready", 32'(req_ready), 32'd0);
         check("gap_active", 32'(active), 32'd1);
         tick();
      end
      req_valid = 4'h0;
      tx_busy   = 1'b0;
      check("grant_id_hold", 32'(grant_id), 32'(w));
      $display("frame %0d: valid=%b winner=%0d byte=%02h connected=%0d sent=%0d",
               frame_no, v, w, b, connected, sent_model);
      frame_no++;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 4'h0;
      req_data  = 32'h0;
      tx_busy   = 1'b0;
      tick();
      req_valid = 4'hF;
      tick();
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_active", 32'(active), 32'd0);
      check("rst_err", 32'(err_timeout), 32'd0);
      check("rst_sent", 32'(sent_count), 32'd0);
      rst       = 1'b0;
      req_valid = 4'h0;

      // Single request from requester 2.
      do_frame(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1'b1);

      // Reset while a frame is in WAIT_DONE.
      req_valid = 4'b0100;
      req_data  = $urandom;
      #1;
      check("mid_ready", 32'(req_ready), 32'b0100);
      tick();
      req_valid = 4'h0;
      tick();
      tx_busy = 1'b1;
      tick();
      tick();
      check("mid_active", 32'(active), 32'd1);
      rst       = 1'b1;
      req_valid = 4'hF;
      tick();
      #1;
      check("mid_rst_ready", 32'(req_ready), 32'd0);
      check("mid_rst_start", 32'(tx_start), 32'd0);
      check("mid_rst_data", 32'(tx_data), 32'd0);
      check("mid_rst_grant", 32'(grant_id), 32'd0);
      check("mid_rst_active", 32'(active), 32'd0);
      check("mid_rst_err", 32'(err_timeout), 32'd0);
      check("mid_rst_sent", 32'(sent_count), 32'd0);
      rst        = 1'b0;
      tx_busy    = 1'b0;
      req_valid  = 4'h0;
      last_model = N - 1;
      sent_model = 0;
      do_frame(4'b0101, $urandom, 1'b1);

      // Full rotation with everyone valid, starting again from requester 0.
      rst = 1'b1;
      tick();
      rst        = 1'b0;
      last_model = N - 1;
      sent_model = 0;
      for (int i = 0; i < 5; i++) begin
         do_frame(4'hF, 32'h4332_2110, 1'b1);
      end
      do_frame(4'hF, 32'h4332_2110, 1'b1);
      do_frame(4'hF, 32'h4332_2110, 1'b1);
      do_frame(4'hF, 32'h4332_2110, 1'b1);

      // last winner is 3 here: 1001 picks 0, then 3.
      do_frame(4'b1001, $urandom, 1'b1);
      do_frame(4'b1001, $urandom, 1'b1);

      // UART disconnected: start timeout, then a normal frame is still accepted.
      do_frame(4'b0010, $urandom, 1'b0);
      do_frame(4'b0110, $urandom, 1'b1);

      for (int i = 0; i < 16; i++) begin
         do_frame(4'($urandom_range(1, 15)), $urandom, ($urandom_range(0, 5) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART_TX instance among NUM_REQ byte producers using round-robin arbitration.
- Accepts a byte from the winning requester and drives UART_TX data_in and start. It then tracks UART_TX busy until the frame completes, and enforces an optional inter-frame idle gap.
- Sits between the producer blocks and UART_TX; the UART_RX side is not involved.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- GAP_CYCLES, 0: idle clocks inserted after each frame before the next grant (0 = none).
- START_TIMEOUT, 16: clocks to wait for tx_busy to rise after tx_start before flagging an error (≥2).

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- req_valid, input, NUM_REQ: per-requester byte-available flag.
- req_data, input, 8*NUM_REQ: per-requester byte; requester k occupies bits [8k+7:8k].
- req_ready, output, NUM_REQ: one-hot accept strobe (combinational).
- tx_data, output, 8: byte to UART_TX data_in (registered).
- tx_start, output, 1: one-cycle start pulse to UART_TX (registered).
- tx_busy, input, 1: UART_TX busy.
- grant_id, output, clog2(NUM_REQ): index of the requester owning the current/last frame.
- active, output, 1: high in any state other than IDLE.
- err_timeout, output, 1: one-cycle pulse when tx_busy fails to rise.
- sent_count, output, 16: frames completed; wraps at 16'hFFFF→0.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE; tx_start=0; tx_data=8'h00; grant_id=0; active=0; err_timeout=0; sent_count=0; req_ready=0.
  - last_grant=NUM_REQ-1, so requester 0 has highest priority first.
  - A reset mid-frame aborts immediately; UART_TX shares the same rst.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If any req_valid is set, the winner is the first set bit searching from last_grant+1 upward, modulo NUM_REQ.
  - req_ready[winner]=1 in that same cycle; this is the transfer.
  - At the edge: tx_data←byte, grant_id←winner, last_grant←winner, state→ISSUE.
  - Exactly one bit of req_ready is high, and only in IDLE with a pending valid. Otherwise req_ready=0.
- ISSUE: tx_start=1 for exactly this one cycle, tx_data stable. Next state is WAIT_BUSY; clear timeout counter.
- WAIT_BUSY:
  - tx_busy=1 → WAIT_DONE.
  - Otherwise increment the counter. When counter reaches START_TIMEOUT-1 with tx_busy still 0: err_timeout=1 for one cycle, then →GAP. sent_count is not incremented.
- WAIT_DONE:
  - tx_busy=0 → sent_count+1, then →GAP if GAP_CYCLES>0, else →IDLE.
- GAP:
  - Counts GAP_CYCLES clocks, then →IDLE.
  - A tx_busy glitch during GAP is ignored.
- Latency: req accepted at cycle T; tx_start at T+1; next grant no earlier than 1 clock after busy falls, plus GAP_CYCLES.
- Timing constraints:
  - Minimum per-frame overhead is IDLE+ISSUE = 2 cycles plus the UART frame.
  - req_valid/req_data changes while not granted are ignored. A requester may drop valid before being granted with no effect.
- Fairness: a requester that has just been granted has lowest priority next round. With all valid continuously, grants rotate 0,1,2,3,0…
- Simultaneous events:
  - rst dominates everything.
  - A busy fall in the same cycle as the counter timeout cannot occur, since busy must rise first.

Test Plan:
- Single request: reset, req_valid=4'b0100, req_data[23:16]=8'hA5 → req_ready=4'b0100 for 1 cycle; tx_start 1 cycle later with tx_data=8'hA5, grant_id=2. Loopback UART_RX reports 8'hA5; sent_count=1.
- Round-robin: all four valid continuously with bytes 8'h10,8'h21,8'h32,8'h43 → frames issued in order 0,1,2,3,0; each req_ready pulse precedes its frame; no overlap of tx_start with tx_busy=1.
- Simultaneous after grant 3: req_valid=4'b1001 with last_grant=3 → requester 0 wins, then 3.
- Timeout: tie tx_busy=0 (UART_TX disconnected), issue one request → err_timeout pulses exactly START_TIMEOUT clocks after tx_start; sent_count stays 0; FSM returns to IDLE and accepts the next request.
- Gap: GAP_CYCLES=5, two back-to-back requests → 5 idle clocks plus 1 between tx_busy falling and the second req_ready.
- Mid-frame reset: assert rst during WAIT_DONE → next clock all outputs at reset values; after release, requester 0 (not the interrupted one) has priority.
